// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//
// LA32R instruction-decode stage sitting between fetch and execute.
// Decodes the integer ALU subset, reads the register file through the
// combinational reg_index/reg_data pair and builds both ALU operands in the
// capture cycle. Decoded entries are held in a 1- or 2-entry output buffer.
// Both sides use a lossless valid/ready handshake, and a synchronous flush
// discards every buffered entry together with any input offered that cycle.
//
// Parameters
//   BUF_DEPTH  1 : single entry, left_ready is combinational
//              2 : skid buffer, left_ready is a register output
//   ALU_OP_W   width of the one-hot out_alu_op (>= 12, bits above 11 are 0)
//
// Optional build macro
//   ID_ILLEGAL_TRAP_EN  adds out_ine. An entry holding an unsupported
//                       encoding stalls further captures until it leaves
//                       on the right side.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               kill all buffered entries (and the offered input)
//   inst, pc            instruction and its address from fetch
//   left_valid/ready    fetch-side handshake
//   reg_index1/2        rj / rk register-file read addresses (combinational)
//   reg_data1/2         register-file read data, same cycle
//   right_valid/ready   execute-side handshake
//   out_*               head entry: pc, inst, operands, one-hot ALU op,
//                       destination write enable/index, decode-valid flag
// -----------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int BUF_DEPTH = 1,
  parameter int ALU_OP_W  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [31:0]         inst,
  input  logic [31:0]         pc,
  input  logic                left_valid,
  output logic                left_ready,
  output logic [4:0]          reg_index1,
  output logic [4:0]          reg_index2,
  input  logic [31:0]         reg_data1,
  input  logic [31:0]         reg_data2,
  output logic                right_valid,
  input  logic                right_ready,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_inst,
  output logic [31:0]         out_src1,
  output logic [31:0]         out_src2,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_wreg_en,
  output logic [4:0]          out_wreg_index,
  output logic                out_inst_valid
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic                out_ine
`endif
);

  // One-hot ALU operation encodings (bit positions 0..11).
  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] alu;
    logic        wen;
    logic [4:0]  widx;
    logic        ivld;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        ine;
`endif
  } entry_t;

  // Sign-extend a 12-bit immediate through a signed intermediate.
  function automatic logic [31:0] sext12(input logic [11:0] imm);
    logic signed [11:0] simm;
    simm = imm;
    return 32'(simm);
  endfunction

  // Zero-extend a 12-bit immediate.
  function automatic logic [31:0] zext12(input logic [11:0] imm);
    return {20'h0, imm};
  endfunction

  // ---------------------------------------------------------------------------
  // Capture cycle: decode and operand selection
  // ---------------------------------------------------------------------------
  assign reg_index1 = inst[9:5];
  assign reg_index2 = inst[14:10];

  logic [11:0] alu_reg;
  logic [11:0] alu_shift;
  logic [11:0] alu_imm12;
  logic        imm_signed;
  logic [31:0] imm20_hi;
  entry_t      dec;

  // Each opcode class keys on a different slice of the upper bits; the keys
  // never collide, so the classes are looked up independently.
  always_comb begin
    alu_reg = '0;
    case (inst[31:15])
      17'h00020: alu_reg = OP_ADD;
      17'h00022: alu_reg = OP_SUB;
      17'h00024: alu_reg = OP_SLT;
      17'h00025: alu_reg = OP_SLTU;
      17'h00028: alu_reg = OP_NOR;
      17'h00029: alu_reg = OP_AND;
      17'h0002a: alu_reg = OP_OR;
      17'h0002b: alu_reg = OP_XOR;
      default:   alu_reg = '0;
    endcase
  end

  always_comb begin
    alu_shift = '0;
    case (inst[31:15])
      17'h00081: alu_shift = OP_SLL;
      17'h00089: alu_shift = OP_SRL;
      17'h00091: alu_shift = OP_SRA;
      default:   alu_shift = '0;
    endcase
  end

  always_comb begin
    alu_imm12  = '0;
    imm_signed = 1'b0;
    case (inst[31:22])
      10'h008: begin alu_imm12 = OP_SLT;  imm_signed = 1'b1; end
      10'h009: begin alu_imm12 = OP_SLTU; imm_signed = 1'b1; end
      10'h00a: begin alu_imm12 = OP_ADD;  imm_signed = 1'b1; end
      10'h00d: alu_imm12 = OP_AND;
      10'h00e: alu_imm12 = OP_OR;
      10'h00f: alu_imm12 = OP_XOR;
      default: alu_imm12 = '0;
    endcase
  end

  assign imm20_hi = {inst[24:5], 12'h000};

  always_comb begin
    dec      = '0;
    dec.pc   = pc;
    dec.inst = inst;
    dec.widx = inst[4:0];
    dec.src1 = reg_data1;
    dec.src2 = reg_data2;
    dec.ivld = 1'b1;
    if (alu_reg != '0) begin
      dec.alu = alu_reg;
    end else if (alu_shift != '0) begin
      dec.alu  = alu_shift;
      dec.src2 = {27'h0, inst[14:10]};
    end else if (alu_imm12 != '0) begin
      dec.alu  = alu_imm12;
      dec.src2 = imm_signed ? sext12(inst[21:10]) : zext12(inst[21:10]);
    end else if (inst[31:25] == 7'h0a) begin
      // lu12i.w: the ALU passes src1 through as the result.
      dec.alu  = OP_LUI;
      dec.src1 = imm20_hi;
      dec.src2 = '0;
    end else if (inst[31:25] == 7'h0e) begin
      // pcaddu12i: plain add of the shifted immediate and the PC.
      dec.alu  = OP_ADD;
      dec.src1 = imm20_hi;
      dec.src2 = pc;
    end else begin
      dec.ivld = 1'b0;
      dec.alu  = '0;
    end
    // r0 is hardwired to zero, so a write to it is suppressed here.
    dec.wen = dec.ivld & (inst[4:0] != 5'd0);
`ifdef ID_ILLEGAL_TRAP_EN
    dec.ine = ~dec.ivld;
`endif
  end

  // ---------------------------------------------------------------------------
  // Output buffer: slot 0 is the head, slot 1 only exists for BUF_DEPTH == 2
  // ---------------------------------------------------------------------------
  entry_t ent0_q, ent0_d;
  entry_t ent1_q, ent1_d;
  logic   vld0_q, vld0_d;
  logic   vld1_q, vld1_d;
  logic   left_ready_q, left_ready_d;
  logic   left_fire, right_fire;
  logic   ine_pend_q, ine_pend_d;

  assign right_fire = vld0_q & right_ready;
  assign left_fire  = left_valid & left_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    if (flush) begin
      // Flush wins over both handshakes; the offered input is dropped too.
      vld0_d = 1'b0;
      vld1_d = 1'b0;
    end else begin
      if (right_fire) begin
        vld0_d = vld1_q;
        vld1_d = 1'b0;
        if (vld1_q) begin
          ent0_d = ent1_q;
        end
      end
      // The new entry lands in the head if it is (or just became) empty,
      // otherwise it queues behind the head.
      if (left_fire) begin
        if (!vld0_d) begin
          ent0_d = dec;
          vld0_d = 1'b1;
        end else if (BUF_DEPTH == 2) begin
          ent1_d = dec;
          vld1_d = 1'b1;
        end
      end
    end
  end

  // An unsupported entry anywhere in the buffer blocks new captures.
`ifdef ID_ILLEGAL_TRAP_EN
  assign ine_pend_q = (vld0_q & ent0_q.ine) | (vld1_q & ent1_q.ine);
  assign ine_pend_d = (vld0_d & ent0_d.ine) | (vld1_d & ent1_d.ine);
`else
  assign ine_pend_q = 1'b0;
  assign ine_pend_d = 1'b0;
`endif

  // Registered ready for the skid buffer is derived from the next state so
  // it is exact in the cycle it becomes visible.
  assign left_ready_d = ~(vld0_d & vld1_d) & ~ine_pend_d;

  always_comb begin
    if (BUF_DEPTH == 2) begin
      left_ready = ~reset & left_ready_q;
    end else begin
      left_ready = ~reset & (~vld0_q | right_ready) & ~ine_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q       <= '0;
      ent1_q       <= '0;
      vld0_q       <= 1'b0;
      vld1_q       <= 1'b0;
      left_ready_q <= 1'b0;
    end else begin
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      vld0_q       <= vld0_d;
      vld1_q       <= vld1_d;
      left_ready_q <= left_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Head entry drives the execute side
  // ---------------------------------------------------------------------------
  assign right_valid    = vld0_q;
  assign out_pc         = ent0_q.pc;
  assign out_inst       = ent0_q.inst;
  assign out_src1       = ent0_q.src1;
  assign out_src2       = ent0_q.src2;
  assign out_wreg_en    = ent0_q.wen;
  assign out_wreg_index = ent0_q.widx;
  assign out_inst_valid = ent0_q.ivld;
`ifdef ID_ILLEGAL_TRAP_EN
  assign out_ine        = ent0_q.ine;
`endif

  always_comb begin
    out_alu_op       = '0;
    out_alu_op[11:0] = ent0_q.alu;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised LA32R decode stage between fetch and execute.
- Decodes the integer ALU subset, reads the regfile and builds operands.
- Holds results in a 1- or 2-entry output buffer with lossless valid/ready handshakes on both sides.
- Adds pipeline flush and correct back-pressure: a stalled entry is held, never dropped.

Parameters:
- BUF_DEPTH, 1: output buffer entries, 1 or 2. With 2 the block is a skid buffer and left_ready is a register output.
- ALU_OP_W, 12: width of the one-hot alu_op field; must be ≥12; bits above 11 are driven 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous; kill all buffered entries
- inst  in  32  instruction from fetch
- pc  in  32  instruction address
- left_valid  in  1  fetch data valid
- left_ready  out  1  stage can accept
- reg_index1  out  5  = inst[9:5] (rj), combinational
- reg_index2  out  5  = inst[14:10] (rk), combinational
- reg_data1  in  32  regfile read data 1, same cycle
- reg_data2  in  32  regfile read data 2, same cycle
- right_valid  out  1  head entry valid
- right_ready  in  1  execute accepts
- out_pc  out  32  head entry PC
- out_inst  out  32  head entry instruction
- out_src1  out  32  operand 1
- out_src2  out  32  operand 2
- out_alu_op  out  ALU_OP_W  one-hot; bits 0..11 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
- out_wreg_en  out  1  writes rd
- out_wreg_index  out  5  rd = inst[4:0]
- out_inst_valid  out  1  instruction decoded as supported

Behaviour:
- Fire conditions: left fire = left_valid & left_ready; right fire = right_valid & right_ready.
- Capture: decode and operand selection happen in the capture cycle; all fields are registered on left fire. Latency is 1 cycle from left fire to right_valid.
- BUF_DEPTH=1:
  - left_ready = ~valid | right_ready (combinational).
  - valid <= left fire ? 1 : (right fire ? 0 : valid).
  - The entry holds unchanged while right_valid & ~right_ready.
- BUF_DEPTH=2:
  - count in {0,1,2}; left_ready = (count != 2), registered.
  - Simultaneous left fire and right fire leaves count unchanged; the new entry is queued behind the head.
  - The head pops on right fire; the second entry becomes the head in the next cycle.
  - Order is strictly FIFO.
- Decode keys on inst[31:15] / inst[31:22] / inst[31:25]:
  - Register ops: add.w 0x00020, sub.w 0x00022, slt 0x00024, sltu 0x00025, nor 0x00028, and 0x00029, or 0x0002a, xor 0x0002b.
  - Shift-immediate ops: slli.w 0x00081, srli.w 0x00089, srai.w 0x00091.
  - 12-bit immediate ops (inst[31:22]): slti 0x008, sltui 0x009, addi.w 0x00a, andi 0x00d, ori 0x00e, xori 0x00f.
  - 20-bit immediate ops (inst[31:25]): lu12i.w 0x0a, pcaddu12i 0x0e.
- Operands:
  - Register ops: src1 = reg_data1, src2 = reg_data2.
  - Shift-immediate: src2 = {27'b0, inst[14:10]}.
  - slti / sltui / addi.w: src2 = sign-extended inst[21:10].
  - andi / ori / xori: src2 = zero-extended inst[21:10].
  - lu12i.w: src1 = {inst[24:5], 12'h0}, src2 = 0, alu_op = lui.
  - pcaddu12i: src1 = {inst[24:5], 12'h0}, src2 = pc, alu_op = add.
- Unsupported encodings: out_inst_valid = 0, alu_op = 0, wreg_en = 0. The entry still flows through.
- Register 0: wreg_en = 0 when rd == 0.
- Flush:
  - Next cycle, all entries are invalid and count = 0.
  - An input offered in the flush cycle is discarded even if left_valid & left_ready.
  - Flush has priority over left fire and right fire.
- Reset: right_valid = 0 and all out_* = 0. left_ready = 1 from the cycle after reset deasserts; left_ready = 0 while reset is asserted.

Optional Feature:
- Macro ID_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output out_ine (1 bit), set for an unsupported encoding.
  - An entry with out_ine = 1 blocks further captures until it fires right: left_ready = 0 while any buffered entry has ine.
- Undefined: no port; unsupported instructions pass through silently as bubbles.

Test Plan:
- add.w 0x00100823, reg_data1 = 5, reg_data2 = 7, right_ready = 1 -> next cycle right_valid = 1, src1 = 5, src2 = 7, alu_op = 0x001, wreg_index = 3, wreg_en = 1.
- addi.w 0x02bffc24 -> src2 = 0xffffffff, alu_op = add. andi 0x037ffc27 -> src2 = 0x00000fff, alu_op = and (0x010).
- lu12i.w 0x142468a5 -> src1 = 0x12345000, alu_op = lui. pcaddu12i 0x1c000026 at pc 0x1c000000 -> src1 = 0x1000, src2 = 0x1c000000, alu_op = add.
- Hold right_ready = 0 for 3 cycles with a continuous stream:
  - BUF_DEPTH=1: left_ready = 0 after the first capture; out_* stable.
  - BUF_DEPTH=2: two entries accepted, then left_ready = 0.
  - After release, entries emerge in order with no loss or duplication.
- flush asserted with count = 2 and left_valid = 1 -> next cycle right_valid = 0, count = 0, the offered instruction never appears.
- Unknown encoding 0xffffffff -> inst_valid = 0, wreg_en = 0. With ID_ILLEGAL_TRAP_EN, ine = 1 and left_ready = 0 until it fires right.
